// File: rtl/digit_scan_mux_pkg.sv
// Shared constants and helpers for the 4-digit multiplexed 7-segment display path.
// BLANK_CODE is also the code the downstream decoder renders as all segments off.
package digit_scan_mux_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam logic [3:0] ANODE_OFF  = 4'b1111;

    typedef logic [1:0] sel_t;

    // Active-low one-hot enable for a display position.
    function automatic logic [3:0] anode_for(input sel_t pos);
        return ~(4'b0001 << pos);
    endfunction

endpackage

// File: rtl/digit_scan_mux_tick.sv
// Free-running prescaler: counts 0..DIV-1 and pulses tick for one cycle at the terminal count.
// DIV=1 degenerates to a tick on every cycle.
module tick_divider #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int             W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0]   LAST = W'(DIV - 1);

    logic [W-1:0] count;

    assign tick = (count == LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (tick)
            count <= '0;
        else
            count <= count + 1'b1;
    end

endmodule

// File: rtl/digit_scan_mux.sv
// Scans four BCD digits onto one shared decoder and four common-anode enables,
// blanking masked positions during the visible-off half of the blink cycle.
module digit_scan_mux
    import digit_scan_mux_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic [3:0] blink_mask,
    output logic [3:0] digit,
    output logic [3:0] anode,
    output logic [1:0] sel
);

    logic       slot_tick;
    logic       blink_tick;
    logic       blink_phase;
    logic [3:0] cur_digit;

    tick_divider #(.DIV(REFRESH_DIV)) u_refresh (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (slot_tick)
    );

    tick_divider #(.DIV(BLINK_DIV)) u_blink (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (blink_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel         <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (slot_tick)
                sel <= sel + 2'd1;
            if (blink_tick)
                blink_phase <= ~blink_phase;
        end
    end

    // NOTE: assign a default before the case so no path leaves cur_digit unassigned (no latch).
    always_comb begin
        cur_digit = digit0;
        case (sel)
            2'd1:    cur_digit = digit1;
            2'd2:    cur_digit = digit2;
            2'd3:    cur_digit = digit3;
            default: cur_digit = digit0;
        endcase
    end

    // Both outputs come from the same pre-update sel, so anode and digit switch together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode <= ANODE_OFF;
            digit <= BLANK_CODE;
        end else begin
            anode <= anode_for(sel);
            digit <= (blink_phase && blink_mask[sel]) ? BLANK_CODE : cur_digit;
        end
    end

endmodule

// File: tb/tb_digit_scan_mux.sv
// Scoreboard bench for digit_scan_mux: a slow-refresh instance (4/16) and a degenerate
// instance (1/16) share stimulus; expectations come from a cycle-index arithmetic model.
module tb_digit_scan_mux;

    localparam int RD_S = 4;
    localparam int RD_F = 1;
    localparam int BD   = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] d0, d1, d2, d3, mask;
    logic [3:0] digit_s, anode_s, digit_f, anode_f;
    logic [1:0] sel_s, sel_f;

    typedef struct {
        logic [3:0] an_s, dg_s, an_f, dg_f;
        logic [1:0] sl_s, sl_f;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   k           = 0;

    always #5 clk = ~clk;

    digit_scan_mux #(.REFRESH_DIV(RD_S), .BLINK_DIV(BD)) dut (
        .clk(clk), .rst_n(rst_n), .digit0(d0), .digit1(d1), .digit2(d2), .digit3(d3),
        .blink_mask(mask), .digit(digit_s), .anode(anode_s), .sel(sel_s)
    );

    digit_scan_mux #(.REFRESH_DIV(RD_F), .BLINK_DIV(BD)) dut_fast (
        .clk(clk), .rst_n(rst_n), .digit0(d0), .digit1(d1), .digit2(d2), .digit3(d3),
        .blink_mask(mask), .digit(digit_f), .anode(anode_f), .sel(sel_f)
    );

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (edge %0d, t=%0t)", name, act, exp, k, $time);
        end
    endtask

    // Edge n after reset release shows the position and phase reached after n-1 edges;
    // sel after edge n has seen n edges.
    function automatic void model(input int n, input int rd, output logic [3:0] an,
                                  output logic [3:0] dg, output logic [1:0] sl);
        logic [3:0] d [4];
        int pos, ph;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        pos = ((n - 1) / rd) % 4;
        ph  = ((n - 1) / BD) % 2;
        an  = 4'b1111;
        an[pos] = 1'b0;
        dg  = (ph == 1 && mask[pos]) ? 4'hF : d[pos];
        sl  = 2'((n / rd) % 4);
    endfunction

    // Called at a negedge with inputs already set for the coming posedge.
    task automatic run_cycle();
        exp_t e;
        k++;
        model(k, RD_S, e.an_s, e.dg_s, e.sl_s);
        model(k, RD_F, e.an_f, e.dg_f, e.sl_f);
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) begin
            d0 = 4'($urandom_range(0, 15));
            d1 = 4'($urandom_range(0, 15));
            d2 = 4'($urandom_range(0, 15));
            d3 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0)
                mask = 4'($urandom_range(0, 15));
            run_cycle();
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " anode"},      anode_s, 4'b1111);
        check({tag, " digit"},      digit_s, 4'hF);
        check({tag, " sel"},        {2'b00, sel_s}, 4'd0);
        check({tag, " fast anode"}, anode_f, 4'b1111);
        check({tag, " fast digit"}, digit_f, 4'hF);
        check({tag, " fast sel"},   {2'b00, sel_f}, 4'd0);
    endtask

    // Monitor: outputs are registered and presented every cycle; compare away from the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("anode",      anode_s, e.an_s);
            check("digit",      digit_s, e.dg_s);
            check("sel",        {2'b00, sel_s}, {2'b00, e.sl_s});
            check("fast anode", anode_f, e.an_f);
            check("fast digit", digit_f, e.dg_f);
            check("fast sel",   {2'b00, sel_f}, {2'b00, e.sl_f});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, %0d expectations pending", q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; d3 = 4'd4;
        mask = 4'b0000;
        repeat (3) @(negedge clk);
        check_reset_state("reset");

        // Full rotation and wrap, then a live change of digit0 while position 0 is active.
        rst_n = 1'b1;
        repeat (18) run_cycle();
        d0 = 4'd9;
        repeat (14) run_cycle();

        // Blink on position 2 plus a non-BCD code on position 3.
        d0 = 4'd1; d3 = 4'hC; mask = 4'b0100;
        repeat (64) run_cycle();

        run_random(150);

        // Land between edges with the slow instance at position 2, then reset asynchronously.
        while ((k / RD_S) % 4 != 2)
            run_cycle();
        rst_n = 1'b0;
        #1;
        check_reset_state("async reset");
        @(negedge clk);
        check_reset_state("reset hold");

        rst_n = 1'b1;
        k = 0;
        mask = 4'b1111;
        repeat (40) run_cycle();
        run_random(40);

        @(posedge clk);
        #2;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
